rf_write_arbiter: RTL and testbench
===================================

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, meaning consecutive blocked cycles of the multi-cycle requester before a pipeline stall is forced; legal range 2..15.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-low reset; sampled on posedge clk.
REQ-004 wb_valid  input  1  pipeline writeback stage requests a register write this cycle.
REQ-005 wb_addr  input  5  writeback destination register.
REQ-006 wb_data  input  32  writeback data.
REQ-007 mc_valid  input  1  multi-cycle unit (mult/div/HI-LO path) holds a result for the register file.
REQ-008 mc_addr  input  5  multi-cycle destination register; stable while mc_valid && !mc_ready.
REQ-009 mc_data  input  32  multi-cycle result; stable while mc_valid && !mc_ready.
REQ-010 mc_ready  output  1  arbiter accepts the multi-cycle result this cycle (combinational).
REQ-011 stall_req  output  1  request to the hazard unit to freeze the pipeline (registered).
REQ-012 RegWrite  output  1  register file write enable (registered).
REQ-013 write_addr  output  5  register file write address (registered).
REQ-014 write_data  output  32  register file write data (registered).

Function
REQ-015 The arbiter SHALL drive the single register file write port from the writeback requester or the multi-cycle requester, never both in one cycle.
REQ-016 Writeback SHALL have fixed priority; it is never back-pressured and is never dropped.
REQ-017 mc_ready SHALL equal (!wb_valid || mc_addr == 0) while reset is high, and 0 while reset is low.
REQ-018 A multi-cycle transfer SHALL occur in a cycle with mc_valid && mc_ready.
REQ-019 Write-port outputs SHALL have one-cycle latency: the cycle after a winning request, RegWrite=1, write_addr/write_data equal the winner's address/data.
REQ-020 A winning request with address 0 SHALL be consumed with RegWrite=0 in the following cycle.
REQ-021 With no winner, the next-cycle RegWrite SHALL be 0; write_addr/write_data hold their previous values.
REQ-022 wait_cnt (4 bits) SHALL increment each cycle mc_valid && !mc_ready, saturating at STARVE_LIMIT, and clear on a transfer or when mc_valid is low.
REQ-023 FSM states: IDLE, WAIT, FORCE.
REQ-024 IDLE->WAIT on mc_valid && !mc_ready; IDLE stays IDLE on a transfer or when mc_valid is low.
REQ-025 WAIT->FORCE when blocked and wait_cnt == STARVE_LIMIT-1; WAIT->IDLE on a transfer or when mc_valid is low.
REQ-026 FORCE->IDLE on a transfer or when mc_valid is low; otherwise FORCE is held.
REQ-027 stall_req SHALL be 1 exactly in cycles where the registered state is FORCE.
REQ-028 In FORCE, writeback SHALL still win when wb_valid=1; the multi-cycle result transfers on the first cycle with wb_valid=0.
REQ-029 Same-cycle requests to the same address SHALL write writeback first and the multi-cycle result in a later cycle; program ordering is the hazard unit's responsibility.
REQ-030 Dropping mc_valid without a transfer is a protocol violation; the arbiter SHALL return to IDLE and clear wait_cnt.

Reset
REQ-031 While reset=0 at posedge clk: state=IDLE, wait_cnt=0, RegWrite=0, write_addr=0, write_data=0, stall_req=0.
REQ-032 Reset mid-operation SHALL discard any pending multi-cycle request with no write issued; the requester re-presents it after reset.

Structure
REQ-033 State encodings (IDLE=2'd0, WAIT=2'd1, FORCE=2'd2) and the default STARVE_LIMIT SHALL live in the shared CPU constants header.
REQ-034 The arbiter SHALL be a single module with no sub-module; it instantiates alongside the register file, and its write-port outputs connect directly to the register file's write ports.

Verification
REQ-035 wb_valid=1, wb_addr=5, wb_data=0xDEADBEEF, mc_valid=0 -> next cycle RegWrite=1, write_addr=5, write_data=0xDEADBEEF.
REQ-036 mc_valid=1, mc_addr=9, mc_data=0x12345678, wb_valid=0 -> mc_ready=1 same cycle; next cycle RegWrite=1, write_addr=9; state stays IDLE.
REQ-037 mc_valid=1 (addr 9) with wb_valid=1 for 6 cycles, STARVE_LIMIT=4 -> mc_ready=0 throughout; stall_req rises after 4 blocked cycles; once wb_valid=0, mc transfers, then stall_req returns to 0 the next cycle.
REQ-038 wb_valid=1, wb_addr=0 and mc_valid=1, mc_addr=0 in the same cycle -> mc_ready=1; next cycle RegWrite=0.
REQ-039 reset=0 asserted while in FORCE with mc_valid=1 -> next cycle stall_req=0, RegWrite=0, mc_ready=0; after reset=1, the re-presented request completes normally.

Source files
------------

// File: rtl/rf_write_arbiter_pkg.sv
// Shared CPU constants for the register-file write arbiter: FSM encodings
// and the default starvation limit of the multi-cycle requester.
package rf_write_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FORCE = 2'd2
    } arb_state_t;

    localparam int DEFAULT_STARVE_LIMIT = 4;

endpackage

// File: rtl/rf_write_arbiter.sv
// Single write port arbiter: writeback has fixed priority, the multi-cycle unit
// waits and forces a pipeline stall once it has been blocked STARVE_LIMIT cycles.
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        mc_valid,
    input  logic [4:0]  mc_addr,
    input  logic [31:0] mc_data,
    output logic        mc_ready,
    output logic        stall_req,
    output logic        RegWrite,
    output logic [4:0]  write_addr,
    output logic [31:0] write_data
);

    localparam logic [3:0] LIMIT    = 4'(STARVE_LIMIT);
    localparam logic [3:0] LIMIT_M1 = 4'(STARVE_LIMIT - 1);

    arb_state_t state;
    arb_state_t next_state;
    logic [3:0] wait_cnt;
    logic       mc_xfer;
    logic       mc_blocked;

    // A result bound for r0 never needs the port, so it is accepted even under writeback.
    assign mc_ready   = reset && (!wb_valid || mc_addr == 5'd0);
    assign mc_xfer    = mc_valid && mc_ready;
    assign mc_blocked = mc_valid && !mc_ready;

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (mc_blocked)
                    next_state = WAIT;
            end
            WAIT: begin
                if (!mc_blocked)
                    next_state = IDLE;
                else if (wait_cnt == LIMIT_M1)
                    next_state = FORCE;
            end
            FORCE: begin
                if (!mc_blocked)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            wait_cnt   <= 4'd0;
            stall_req  <= 1'b0;
            RegWrite   <= 1'b0;
            write_addr <= 5'd0;
            write_data <= 32'd0;
        end else begin
            state     <= next_state;
            stall_req <= (next_state == FORCE);

            if (mc_blocked)
                wait_cnt <= (wait_cnt >= LIMIT) ? LIMIT : wait_cnt + 4'd1;
            else
                wait_cnt <= 4'd0;

            // Address 0 still wins the slot but must never reach the register file.
            if (wb_valid) begin
                RegWrite   <= (wb_addr != 5'd0);
                write_addr <= wb_addr;
                write_data <= wb_data;
            end else if (mc_xfer) begin
                RegWrite   <= (mc_addr != 5'd0);
                write_addr <= mc_addr;
                write_data <= mc_data;
            end else begin
                RegWrite <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed self-checking bench for rf_write_arbiter with STARVE_LIMIT=4.
module tb_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        mc_valid;
    logic [4:0]  mc_addr;
    logic [31:0] mc_data;
    logic        mc_ready;
    logic        stall_req;
    logic        RegWrite;
    logic [4:0]  write_addr;
    logic [31:0] write_data;

    int check_cnt = 0;
    int pass_cnt  = 0;

    rf_write_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .wb_valid   (wb_valid),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .mc_valid   (mc_valid),
        .mc_addr    (mc_addr),
        .mc_data    (mc_data),
        .mc_ready   (mc_ready),
        .stall_req  (stall_req),
        .RegWrite   (RegWrite),
        .write_addr (write_addr),
        .write_data (write_data)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        reset = 1'b0; wb_valid = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
        mc_valid = 1'b1; mc_addr = 5'd9; mc_data = 32'h0; #1;
        check_cnt++; if (mc_ready !== 1'b0) $display("[TB] FAIL reset_mc_ready: got %b expected 0", mc_ready); else pass_cnt++;
        repeat (2) @(posedge clk); #1;
        check_cnt++; if (RegWrite !== 1'b0) $display("[TB] FAIL reset_regwrite: got %b expected 0", RegWrite); else pass_cnt++;
        check_cnt++; if (write_addr !== 5'd0) $display("[TB] FAIL reset_addr: got %0d expected 0", write_addr); else pass_cnt++;
        check_cnt++; if (write_data !== 32'd0) $display("[TB] FAIL reset_data: got %h expected 0", write_data); else pass_cnt++;
        check_cnt++; if (stall_req !== 1'b0) $display("[TB] FAIL reset_stall: got %b expected 0", stall_req); else pass_cnt++;
        mc_valid = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_wb_write();
        wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
        @(posedge clk); #1; wb_valid = 1'b0;
        check_cnt++; if (RegWrite !== 1'b1) $display("[TB] FAIL wb_regwrite: got %b expected 1", RegWrite); else pass_cnt++;
        check_cnt++; if (write_addr !== 5'd5) $display("[TB] FAIL wb_addr: got %0d expected 5", write_addr); else pass_cnt++;
        check_cnt++; if (write_data !== 32'hDEADBEEF) $display("[TB] FAIL wb_data: got %h expected deadbeef", write_data); else pass_cnt++;
        @(posedge clk); #1;
        check_cnt++; if (RegWrite !== 1'b0) $display("[TB] FAIL idle_regwrite: got %b expected 0", RegWrite); else pass_cnt++;
        check_cnt++; if (write_addr !== 5'd5) $display("[TB] FAIL idle_addr_hold: got %0d expected 5", write_addr); else pass_cnt++;
        check_cnt++; if (write_data !== 32'hDEADBEEF) $display("[TB] FAIL idle_data_hold: got %h expected deadbeef", write_data); else pass_cnt++;
    endtask

    task automatic test_mc_write();
        mc_valid = 1'b1; mc_addr = 5'd9; mc_data = 32'h12345678; #1;
        check_cnt++; if (mc_ready !== 1'b1) $display("[TB] FAIL mc_ready_free: got %b expected 1", mc_ready); else pass_cnt++;
        @(posedge clk); #1; mc_valid = 1'b0;
        check_cnt++; if (RegWrite !== 1'b1) $display("[TB] FAIL mc_regwrite: got %b expected 1", RegWrite); else pass_cnt++;
        check_cnt++; if (write_addr !== 5'd9) $display("[TB] FAIL mc_addr: got %0d expected 9", write_addr); else pass_cnt++;
        check_cnt++; if (write_data !== 32'h12345678) $display("[TB] FAIL mc_data: got %h expected 12345678", write_data); else pass_cnt++;
        check_cnt++; if (stall_req !== 1'b0) $display("[TB] FAIL mc_no_stall: got %b expected 0", stall_req); else pass_cnt++;
    endtask

    task automatic test_starve_force();
        wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'h00000033;
        mc_valid = 1'b1; mc_addr = 5'd9; mc_data = 32'h99990009; #1;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk); #1;
            check_cnt++; if (mc_ready !== 1'b0) $display("[TB] FAIL starve_mc_ready[%0d]: got %b expected 0", i, mc_ready); else pass_cnt++;
            check_cnt++; if (stall_req !== (i >= 4)) $display("[TB] FAIL starve_stall[%0d]: got %b expected %b", i, stall_req, (i >= 4)); else pass_cnt++;
            check_cnt++; if (write_addr !== 5'd3) $display("[TB] FAIL starve_wb_addr[%0d]: got %0d expected 3", i, write_addr); else pass_cnt++;
        end
        wb_valid = 1'b0; #1;
        check_cnt++; if (mc_ready !== 1'b1) $display("[TB] FAIL force_mc_ready: got %b expected 1", mc_ready); else pass_cnt++;
        @(posedge clk); #1; mc_valid = 1'b0;
        check_cnt++; if (RegWrite !== 1'b1) $display("[TB] FAIL force_regwrite: got %b expected 1", RegWrite); else pass_cnt++;
        check_cnt++; if (write_addr !== 5'd9) $display("[TB] FAIL force_addr: got %0d expected 9", write_addr); else pass_cnt++;
        check_cnt++; if (write_data !== 32'h99990009) $display("[TB] FAIL force_data: got %h expected 99990009", write_data); else pass_cnt++;
        check_cnt++; if (stall_req !== 1'b0) $display("[TB] FAIL force_release: got %b expected 0", stall_req); else pass_cnt++;
    endtask

    task automatic test_zero_addr();
        wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'h11111111;
        mc_valid = 1'b1; mc_addr = 5'd0; mc_data = 32'h22222222; #1;
        check_cnt++; if (mc_ready !== 1'b1) $display("[TB] FAIL zero_mc_ready: got %b expected 1", mc_ready); else pass_cnt++;
        @(posedge clk); #1; wb_valid = 1'b0; mc_valid = 1'b0;
        check_cnt++; if (RegWrite !== 1'b0) $display("[TB] FAIL zero_regwrite: got %b expected 0", RegWrite); else pass_cnt++;
        check_cnt++; if (stall_req !== 1'b0) $display("[TB] FAIL zero_stall: got %b expected 0", stall_req); else pass_cnt++;
    endtask

    task automatic test_same_addr();
        wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'hAAAA0001;
        mc_valid = 1'b1; mc_addr = 5'd7; mc_data = 32'hBBBB0002; #1;
        check_cnt++; if (mc_ready !== 1'b0) $display("[TB] FAIL same_mc_ready: got %b expected 0", mc_ready); else pass_cnt++;
        @(posedge clk); #1; wb_valid = 1'b0;
        check_cnt++; if (write_data !== 32'hAAAA0001) $display("[TB] FAIL same_wb_first: got %h expected aaaa0001", write_data); else pass_cnt++;
        #1;
        check_cnt++; if (mc_ready !== 1'b1) $display("[TB] FAIL same_mc_ready2: got %b expected 1", mc_ready); else pass_cnt++;
        @(posedge clk); #1; mc_valid = 1'b0;
        check_cnt++; if (RegWrite !== 1'b1) $display("[TB] FAIL same_mc_regwrite: got %b expected 1", RegWrite); else pass_cnt++;
        check_cnt++; if (write_data !== 32'hBBBB0002) $display("[TB] FAIL same_mc_second: got %h expected bbbb0002", write_data); else pass_cnt++;
    endtask

    task automatic test_drop_mc();
        wb_valid = 1'b1; wb_addr = 5'd4; wb_data = 32'h44444444;
        mc_valid = 1'b1; mc_addr = 5'd10; mc_data = 32'h0000AAAA;
        repeat (3) @(posedge clk); #1;
        check_cnt++; if (stall_req !== 1'b0) $display("[TB] FAIL drop_pre_stall: got %b expected 0", stall_req); else pass_cnt++;
        mc_valid = 1'b0;
        @(posedge clk); #1;
        mc_valid = 1'b1;
        repeat (3) @(posedge clk); #1;
        check_cnt++; if (stall_req !== 1'b0) $display("[TB] FAIL drop_cnt_cleared: got %b expected 0", stall_req); else pass_cnt++;
        @(posedge clk); #1;
        check_cnt++; if (stall_req !== 1'b1) $display("[TB] FAIL drop_then_force: got %b expected 1", stall_req); else pass_cnt++;
        wb_valid = 1'b0;
        @(posedge clk); #1; mc_valid = 1'b0;
        check_cnt++; if (write_addr !== 5'd10) $display("[TB] FAIL drop_mc_addr: got %0d expected 10", write_addr); else pass_cnt++;
        check_cnt++; if (stall_req !== 1'b0) $display("[TB] FAIL drop_release: got %b expected 0", stall_req); else pass_cnt++;
    endtask

    task automatic test_reset_in_force();
        wb_valid = 1'b1; wb_addr = 5'd2; wb_data = 32'h22220002;
        mc_valid = 1'b1; mc_addr = 5'd11; mc_data = 32'hCAFE0011;
        repeat (4) @(posedge clk); #1;
        check_cnt++; if (stall_req !== 1'b1) $display("[TB] FAIL rst_force_entry: got %b expected 1", stall_req); else pass_cnt++;
        reset = 1'b0; #1;
        check_cnt++; if (mc_ready !== 1'b0) $display("[TB] FAIL rst_mc_ready_comb: got %b expected 0", mc_ready); else pass_cnt++;
        @(posedge clk); #1;
        check_cnt++; if (stall_req !== 1'b0) $display("[TB] FAIL rst_stall: got %b expected 0", stall_req); else pass_cnt++;
        check_cnt++; if (RegWrite !== 1'b0) $display("[TB] FAIL rst_regwrite: got %b expected 0", RegWrite); else pass_cnt++;
        check_cnt++; if (mc_ready !== 1'b0) $display("[TB] FAIL rst_mc_ready: got %b expected 0", mc_ready); else pass_cnt++;
        reset = 1'b1; wb_valid = 1'b0; #1;
        check_cnt++; if (mc_ready !== 1'b1) $display("[TB] FAIL rst_represent_ready: got %b expected 1", mc_ready); else pass_cnt++;
        @(posedge clk); #1; mc_valid = 1'b0;
        check_cnt++; if (RegWrite !== 1'b1) $display("[TB] FAIL rst_represent_regwrite: got %b expected 1", RegWrite); else pass_cnt++;
        check_cnt++; if (write_addr !== 5'd11) $display("[TB] FAIL rst_represent_addr: got %0d expected 11", write_addr); else pass_cnt++;
        check_cnt++; if (write_data !== 32'hCAFE0011) $display("[TB] FAIL rst_represent_data: got %h expected cafe0011", write_data); else pass_cnt++;
        check_cnt++; if (stall_req !== 1'b0) $display("[TB] FAIL rst_represent_stall: got %b expected 0", stall_req); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_wb_write();
        test_mc_write();
        test_starve_force();
        test_zero_addr();
        test_same_addr();
        test_drop_mc();
        test_reset_in_force();
        $display("[TB] %0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
